sccb_slave_regs: RTL
====================

SCCB_SLAVE_REGS -- requirements
Module: sccb_slave_regs

Interface
REQ-001 SHALL have parameter DEVICE_ID, default 8'h42, the 8-bit write address; the read address is DEVICE_ID|1.
REQ-002 SHALL have parameter FILTER_LEN, default 3, the number of consecutive equal Clk samples needed to accept an SCL or SDA level change.
REQ-003 Clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 i2c_sclk  input  1  SCCB clock from the master; asynchronous to Clk.
REQ-006 i2c_sdat  inout  1  SCCB data; open-drain (drives 0 or Z only).
REQ-007 reg_wr  output  1  one-Clk strobe per accepted data byte.
REQ-008 reg_addr  output  8  register address for reg_wr.
REQ-009 reg_wdata  output  8  data for reg_wr.
REQ-010 busy  output  1  high from START until STOP or bus abandonment.

Function
REQ-011 SHALL pass SCL and SDA through 2-flop synchronisers, then FILTER_LEN glitch filters; edges SHALL be detected on the filtered signals.
REQ-012 START = filtered SDA falls while SCL is high; STOP = filtered SDA rises while SCL is high.
REQ-013 SHALL sample SDA on the SCL rising edge; the SDA drive SHALL change on the Clk cycle after an SCL falling edge is detected.
REQ-014 States: IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-015 IDLE->DEV on START; START in any other state (repeated start) SHALL also go to DEV with the bit counter cleared.
REQ-016 STOP in any state SHALL go to IDLE and release SDA.
REQ-017 DEV: 8 bits, MSB first. On DEVICE_ID -> DEV_ACK (drive 0). On DEVICE_ID|1 -> DEV_ACK, then RDATA. Any other value SHALL leave SDA released and go to IDLE.
REQ-018 REG: 8 bits load the 8-bit pointer -> REG_ACK (drive 0) -> WDATA.
REQ-019 WDATA: on the 8th bit SHALL write the byte into the internal 256x8 array at the pointer and pulse reg_wr with reg_addr = pointer and reg_wdata = byte, exactly one Clk; then WDATA_ACK (drive 0); the pointer SHALL increment mod 256 (0xFF->0x00).
REQ-020 A STOP or START before the 8th data bit SHALL discard the partial byte with no reg_wr.
REQ-021 Each ACK drive SHALL last from the SCL fall after bit 8 to the next SCL fall.
REQ-022 An SCL-high time above 65535 Clk while not IDLE SHALL be treated as bus abandonment: go to IDLE and release SDA.

Reset
REQ-023 On Rst: state IDLE, SDA released, reg_wr=0, reg_addr=0, reg_wdata=0, busy=0, pointer=0, filters preset high.
REQ-024 Rst asserted mid-transfer SHALL release SDA in the same Clk.
REQ-025 Rst SHALL NOT clear the register array contents.

Configuration
REQ-026 Macro SCCB_SLAVE_READ_EN.
- Defined: RDATA shifts out array[pointer] MSB first, then RDATA_ACK samples the master's ACK. Master ACK (0) -> pointer+1, back to RDATA. Master NACK (1) -> IDLE.
- Undefined: DEVICE_ID|1 SHALL be NACKed as a foreign address, and no read logic or array read port is synthesised.

Structure
REQ-027 A shared package/include SHALL hold the state encodings, the abandonment timeout constant (65535) and the default DEVICE_ID.
REQ-028 One sub-module, sccb_line_filter (synchroniser, glitch filter, rise/fall detect), SHALL be instantiated twice, once for SCL and once for SDA.

Verification
REQ-029 Write 0x42, 0x12, 0x80, STOP -> three ACK lows; one reg_wr with reg_addr=0x12 and reg_wdata=0x80; busy low after STOP.
REQ-030 Address 0x60 -> SDA high at the ACK slot; no reg_wr; state IDLE.
REQ-031 Burst 0x42, 0xFF, 0x11, 0x22 -> reg_wr pairs (0xFF,0x11) then (0x00,0x22).
REQ-032 STOP after 4 data bits -> no reg_wr; the next transfer completes normally.
REQ-033 With the macro on: write 0x42, 0x0A, 0x5C; then 0x42, 0x0A, repeated START, 0x43, read 1 byte with NACK -> returns 0x5C. With the macro off: 0x43 is NACKed.
REQ-034 2-Clk SDA glitch while SCL is high with FILTER_LEN=3 -> no START/STOP detected; Rst mid-ACK -> SDA released in the same cycle.

Source files
------------

// File: rtl/sccb_slave_regs_pkg.sv
// sccb_slave_regs_pkg: FSM state encoding, SCL-high abandonment timeout and
// the default SCCB device address shared by the slave and its sub-blocks.
package sccb_slave_regs_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } sccb_state_e;

  localparam logic [15:0] ABANDON_TIMEOUT   = 16'd65535;
  localparam logic [7:0]  DEFAULT_DEVICE_ID = 8'h42;

endpackage

// File: rtl/sccb_line_filter.sv
// sccb_line_filter: two-flop synchroniser, FILTER_LEN-sample glitch filter and
// rise/fall detection for one SCCB line. The filtered level and the edge
// strobes come out of the same register, so an edge strobe coincides with the
// first cycle of the new filtered level. Everything presets high on Rst
// (idle bus level).
module sccb_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic Clk,
  input  logic Rst,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic [1:0]    sync_q;
  logic [CW-1:0] run_cnt;

  // Synchronise, then accept a new level only after FILTER_LEN equal samples.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q  <= 2'b11;
      level   <= 1'b1;
      run_cnt <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_in};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (sync_q[1] == level) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        level   <= sync_q[1];
        run_cnt <= '0;
        rise    <= sync_q[1];
        fall    <= ~sync_q[1];
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sccb_slave_regs.sv
// sccb_slave_regs: SCCB (I2C-style) slave with a 256x8 register array.
// Writes: START, DEVICE_ID, register pointer, data bytes (auto-increment).
// Optional read support is built when SCCB_SLAVE_READ_EN is defined;
// otherwise the read address is NACKed like any foreign address.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | bus free or transfer not addressed to us
// DEV       | shifting in the device address byte
// DEV_ACK   | driving ACK for the device address
// REG       | shifting in the register pointer
// REG_ACK   | driving ACK for the pointer
// WDATA     | shifting in a write data byte
// WDATA_ACK | driving ACK for a write data byte
// RDATA     | shifting out array[pointer], MSB first
// RDATA_ACK | released, sampling the master's ACK/NACK
module sccb_slave_regs
  import sccb_slave_regs_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID  = DEFAULT_DEVICE_ID,
  parameter int         FILTER_LEN = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       busy
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .Clk    (Clk),
    .Rst    (Rst),
    .line_in(i2c_sclk),
    .level  (scl_f),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .Clk    (Clk),
    .Rst    (Rst),
    .line_in(i2c_sdat),
    .level  (sda_f),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  sccb_state_e state_q, state_n;
  logic [2:0]  bit_cnt_q, bit_cnt_n;
  logic [6:0]  shreg_q, shreg_n;
  logic [7:0]  ptr_q, ptr_n;
  logic        sda_low_q, sda_low_n;
  logic        busy_q, busy_n;
  logic        reg_wr_n;
  logic [7:0]  reg_addr_n, reg_wdata_n;
  logic [7:0]  rx_byte;
  logic        mem_we;
  logic [15:0] tmr_q;
  logic        start_det, stop_det, abandon;
  logic [7:0]  mem [256];
`ifdef SCCB_SLAVE_READ_EN
  logic        rd_mode_q, rd_mode_n;
  logic [7:0]  rd_byte;

  assign rd_byte = mem[ptr_q];
`endif

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign abandon   = busy_q & scl_f & (tmr_q == '0);

  // Open-drain data line; Rst releases it combinationally.
  assign i2c_sdat = (sda_low_q && !Rst) ? 1'b0 : 1'bz;
  assign busy     = busy_q;

  // SCL-high watchdog: reload whenever SCL is low or the bus is free.
  always_ff @(posedge Clk) begin
    if (Rst || !busy_q || !scl_f) tmr_q <= ABANDON_TIMEOUT;
    else if (tmr_q != '0)         tmr_q <= tmr_q - 16'd1;
  end

  // Next-state, shift register, pointer and strobe decode.
  always_comb begin
    state_n     = state_q;
    bit_cnt_n   = bit_cnt_q;
    shreg_n     = shreg_q;
    ptr_n       = ptr_q;
    sda_low_n   = sda_low_q;
    busy_n      = busy_q;
    reg_wr_n    = 1'b0;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;
    mem_we      = 1'b0;
    rx_byte     = {shreg_q, sda_f};
`ifdef SCCB_SLAVE_READ_EN
    rd_mode_n   = rd_mode_q;
`endif
    if (abandon || stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_low_n = 1'b0;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n   = DEV;
      bit_cnt_n = '0;
      sda_low_n = 1'b0;
      busy_n    = 1'b1;
    end else begin
      case (state_q)
        DEV, REG, WDATA: begin
          if (scl_rise) begin
            shreg_n   = rx_byte[6:0];
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == DEV) begin
                if (rx_byte == DEVICE_ID) begin
                  state_n = DEV_ACK;
`ifdef SCCB_SLAVE_READ_EN
                  rd_mode_n = 1'b0;
                end else if (rx_byte == (DEVICE_ID | 8'h01)) begin
                  state_n   = DEV_ACK;
                  rd_mode_n = 1'b1;
`endif
                end else begin
                  state_n = IDLE;
                end
              end else if (state_q == REG) begin
                ptr_n   = rx_byte;
                state_n = REG_ACK;
              end else begin
                mem_we      = 1'b1;
                reg_wr_n    = 1'b1;
                reg_addr_n  = ptr_q;
                reg_wdata_n = rx_byte;
                ptr_n       = ptr_q + 8'd1;
                state_n     = WDATA_ACK;
              end
            end
          end
        end
        // First SCL fall asserts ACK, the next one ends the ACK clock.
        DEV_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_n = 1'b1;
            end else begin
              sda_low_n = 1'b0;
              bit_cnt_n = '0;
              if (state_q == DEV_ACK) begin
                state_n = REG;
`ifdef SCCB_SLAVE_READ_EN
                if (rd_mode_q) begin
                  state_n   = RDATA;
                  sda_low_n = ~rd_byte[7];
                end
`endif
              end else begin
                state_n = WDATA;
              end
            end
          end
        end
`ifdef SCCB_SLAVE_READ_EN
        // bit_cnt holds the number of bits already clocked out.
        RDATA: begin
          if (scl_fall) sda_low_n = ~rd_byte[3'd7 - bit_cnt_q];
          if (scl_rise) begin
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_n = RDATA_ACK;
          end
        end
        RDATA_ACK: begin
          if (scl_fall) sda_low_n = 1'b0;
          if (scl_rise) begin
            if (!sda_f) begin
              ptr_n   = ptr_q + 8'd1;
              state_n = RDATA;
            end else begin
              state_n = IDLE;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
`ifdef SCCB_SLAVE_READ_EN
      rd_mode_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      shreg_q   <= shreg_n;
      ptr_q     <= ptr_n;
      sda_low_q <= sda_low_n;
      busy_q    <= busy_n;
      reg_wr    <= reg_wr_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
`ifdef SCCB_SLAVE_READ_EN
      rd_mode_q <= rd_mode_n;
`endif
    end
  end

  // Register array keeps its contents across Rst.
  always_ff @(posedge Clk) begin
    if (mem_we && !Rst) mem[ptr_q] <= rx_byte;
  end

endmodule
